ryu_anim_seq: RTL

- Downstream consumer of the fighter movement stage.
- Takes the per-frame movement flags (Jump, Crouch, Left, Right) plus a punch request, and runs an animation state machine with per-frame hold counters.
- Emits the sprite-ROM frame index that the fighter sprite renderer draws at the fighter's X/Y.
- One instance per fighter, clocked by frame_clk.

---
 rtl/ryu_anim_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ryu_anim_seq.sv
// Fighter animation sequencer: picks the animation from movement/punch flags
// and steps the sprite-ROM frame index with per-state hold counters.
module ryu_anim_seq #(
  parameter int IDLE_BASE    = 0,
  parameter int IDLE_FRAMES  = 4,
  parameter int IDLE_HOLD    = 8,
  parameter int WALK_BASE    = 4,
  parameter int WALK_FRAMES  = 5,
  parameter int WALK_HOLD    = 6,
  parameter int CROUCH_IDX   = 9,
  parameter int JUMP_BASE    = 10,
  parameter int JUMP_FRAMES  = 7,
  parameter int JUMP_HOLD    = 5,
  parameter int PUNCH_BASE   = 17,
  parameter int PUNCH_FRAMES = 3,
  parameter int PUNCH_HOLD   = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       Jump,
  input  logic       Crouch,
  input  logic       Left,
  input  logic       Right,
  input  logic       Punch,
  output logic [4:0] FrameIdx,
  output logic [2:0] AnimState,
  output logic       Busy
);

  // state  | meaning
  // IDLE   | standing loop
  // WALK_F | walk cycle, forward playback (Right)
  // WALK_B | walk cycle, reverse playback (Left)
  // CROUCH | single static sprite
  // JUMP   | airborne, plays once and holds last frame
  // PUNCH  | attack, runs to completion, Busy high
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WALK_F = 3'd1,
    S_WALK_B = 3'd2,
    S_CROUCH = 3'd3,
    S_JUMP   = 3'd4,
    S_PUNCH  = 3'd5
  } state_t;

  localparam logic [3:0] IDLE_LAST  = 4'(IDLE_FRAMES - 1);
  localparam logic [3:0] WALK_LAST  = 4'(WALK_FRAMES - 1);
  localparam logic [3:0] JUMP_LAST  = 4'(JUMP_FRAMES - 1);
  localparam logic [3:0] PUNCH_LAST = 4'(PUNCH_FRAMES - 1);

  state_t     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] off_q, off_d;
  logic [4:0] frame_q, frame_d;
  logic       busy_q, busy_d;
  logic       punch_q, punch_d;
  logic       arm_q, arm_d;
  logic       punch_req, punch_done;
  logic [3:0] hold_lim;
  logic [4:0] base_v;

  function automatic state_t pick(input logic req, input logic jump,
                                  input logic crouch, input logic left,
                                  input logic right);
    state_t s;
    if (req && !jump)  s = S_PUNCH;
    else if (jump)     s = S_JUMP;
    else if (crouch)   s = S_CROUCH;
    else if (right)    s = S_WALK_F;
    else if (left)     s = S_WALK_B;
    else               s = S_IDLE;
    return s;
  endfunction

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      hold_q  <= 4'd0;
      off_q   <= 4'd0;
      frame_q <= 5'(IDLE_BASE);
      busy_q  <= 1'b0;
      punch_q <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      off_q   <= off_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      punch_q <= punch_d;
      arm_q   <= arm_d;
    end
  end

  // arm_q masks the first edge after reset so a Punch held through reset
  // must be released and pressed again before it attacks.
  always_comb begin
    punch_d    = Punch;
    arm_d      = 1'b1;
    punch_req  = arm_q & Punch & ~punch_q;
    punch_done = (hold_q == 4'(PUNCH_HOLD - 1)) && (off_q == PUNCH_LAST);
    state_d    = S_IDLE;
    case (state_q)
      S_PUNCH:  state_d = punch_done ? pick(1'b0, Jump, Crouch, Left, Right) : S_PUNCH;
      S_IDLE, S_WALK_F, S_WALK_B, S_CROUCH, S_JUMP:
                state_d = pick(punch_req, Jump, Crouch, Left, Right);
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      S_IDLE:            hold_lim = 4'(IDLE_HOLD);
      S_WALK_F, S_WALK_B: hold_lim = 4'(WALK_HOLD);
      S_JUMP:            hold_lim = 4'(JUMP_HOLD);
      S_PUNCH:           hold_lim = 4'(PUNCH_HOLD);
      default:           hold_lim = 4'd1;
    endcase

    hold_d = hold_q + 4'd1;
    off_d  = off_q;
    if (state_d != state_q) begin
      hold_d = 4'd0;
      off_d  = (state_d == S_WALK_B) ? WALK_LAST : 4'd0;
    end else if (state_q == S_CROUCH) begin
      hold_d = 4'd0;
      off_d  = 4'd0;
    end else if (hold_q == hold_lim - 4'd1) begin
      hold_d = 4'd0;
      case (state_q)
        S_IDLE:   off_d = (off_q == IDLE_LAST) ? 4'd0 : off_q + 4'd1;
        S_WALK_F: off_d = (off_q == WALK_LAST) ? 4'd0 : off_q + 4'd1;
        S_WALK_B: off_d = (off_q == 4'd0) ? WALK_LAST : off_q - 4'd1;
        S_JUMP:   off_d = (off_q == JUMP_LAST) ? off_q : off_q + 4'd1;
        S_PUNCH:  off_d = off_q + 4'd1;
        default:  off_d = 4'd0;
      endcase
    end

    case (state_d)
      S_WALK_F, S_WALK_B: base_v = 5'(WALK_BASE);
      S_CROUCH:           base_v = 5'(CROUCH_IDX);
      S_JUMP:             base_v = 5'(JUMP_BASE);
      S_PUNCH:            base_v = 5'(PUNCH_BASE);
      default:            base_v = 5'(IDLE_BASE);
    endcase
    frame_d = base_v + {1'b0, off_d};
    busy_d  = (state_d == S_PUNCH);
  end

  assign FrameIdx  = frame_q;
  assign AnimState = state_q;
  assign Busy      = busy_q;

endmodule
